// File: rtl/plic_target_claim_if.sv
// plic_target_claim_if: request, config, claim/complete and eip bundle of one PLIC target
interface plic_target_claim_if;
  logic [31:0] interrupt_request;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [4:0]  cfg_idx;
  logic [31:0] cfg_wdata;
  logic        claim_req;
  logic        claim_valid;
  logic [31:0] claim_id;
  logic        complete_req;
  logic [31:0] complete_id;
  logic        interrupt_completion_notif;
  logic [31:0] interrupt_completion_ID;
  logic        eip;
  modport master (
    output interrupt_request, cfg_we, cfg_sel, cfg_idx, cfg_wdata, claim_req, complete_req, complete_id,
    input  claim_valid, claim_id, interrupt_completion_notif, interrupt_completion_ID, eip
  );
  modport slave (
    input  interrupt_request, cfg_we, cfg_sel, cfg_idx, cfg_wdata, claim_req, complete_req, complete_id,
    output claim_valid, claim_id, interrupt_completion_notif, interrupt_completion_ID, eip
  );
endinterface

// File: rtl/plic_target_claim.sv
// plic_target_claim: PLIC target arbitration with claim/complete; PLIC_THRESHOLD_EN adds a threshold register
module plic_target_claim #(
  parameter int PRIORITY_LEVELS = 32,
  parameter int INTERRUPTS      = 8
) (
  input logic clk,
  input logic rst_n,
  plic_target_claim_if.slave bus
);
  localparam logic [31:0] IMASK = 32'((64'd1 << INTERRUPTS) - 64'd1);
  localparam logic [31:0] PMAX  = 32'(PRIORITY_LEVELS - 1);
  logic [31:0] pending, in_service, enable, pend_nxt, claim_oh, comp_oh;
  logic [4:0]  prio [INTERRUPTS];
  logic [4:0]  threshold, best_id, best_prio, nxt_id, nxt_prio, cfg_sat;
  logic        comp_fire;
  assign cfg_sat   = bus.cfg_wdata > PMAX ? PMAX[4:0] : bus.cfg_wdata[4:0];
  assign claim_oh  = (bus.claim_req && best_prio != 5'd0) ? 32'd1 << (best_id - 5'd1) : 32'd0;
  assign comp_oh   = (bus.complete_id != 32'd0 && bus.complete_id <= 32'(INTERRUPTS)) ? 32'd1 << (bus.complete_id[4:0] - 5'd1) : 32'd0;
  assign comp_fire = bus.complete_req && |(in_service & comp_oh);
  assign pend_nxt  = (pending & ~claim_oh) | (bus.interrupt_request & IMASK);
  // arbitrate on post-claim pending so a back-to-back claim never sees the winner twice
  always_comb begin
    nxt_id   = '0;
    nxt_prio = '0;
    for (int i = 0; i < INTERRUPTS; i++)
      if (pend_nxt[i] && enable[i] && prio[i] != 5'd0 && prio[i] > threshold && prio[i] > nxt_prio) begin
        nxt_id   = 5'(i + 1);
        nxt_prio = prio[i];
      end
  end
`ifdef PLIC_THRESHOLD_EN
  // threshold register, saturated like the priorities
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) threshold <= '0;
    else if (bus.cfg_we && bus.cfg_sel == 2'd2) threshold <= cfg_sat;
`else
  assign threshold = '0;
`endif
  // per-source priorities; writes to unimplemented sources never match an index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < INTERRUPTS; i++) prio[i] <= '0;
    else for (int i = 0; i < INTERRUPTS; i++)
      if (bus.cfg_we && bus.cfg_sel == 2'd0 && bus.cfg_idx == 5'(i)) prio[i] <= cfg_sat;
  // pending/in-service tracking, winner register and claim/complete responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending                         <= '0;
      in_service                      <= '0;
      enable                          <= '0;
      best_id                         <= '0;
      best_prio                       <= '0;
      bus.eip                         <= 1'b0;
      bus.claim_valid                 <= 1'b0;
      bus.claim_id                    <= '0;
      bus.interrupt_completion_notif  <= 1'b0;
      bus.interrupt_completion_ID     <= '0;
    end else begin
      pending                         <= pend_nxt;
      in_service                      <= (in_service & ~(comp_fire ? comp_oh : 32'd0)) | claim_oh;
      enable                          <= (bus.cfg_we && bus.cfg_sel == 2'd1) ? bus.cfg_wdata & IMASK : enable;
      best_id                         <= nxt_id;
      best_prio                       <= nxt_prio;
      bus.eip                         <= nxt_id != 5'd0;
      bus.claim_valid                 <= bus.claim_req;
      bus.claim_id                    <= bus.claim_req ? {27'b0, best_id} : bus.claim_id;
      bus.interrupt_completion_notif  <= comp_fire;
      bus.interrupt_completion_ID     <= comp_fire ? bus.complete_id : bus.interrupt_completion_ID;
    end
endmodule

// File: tb/tb_plic_target_claim.sv
// tb_plic_target_claim: vector table with claim/completion scoreboard plus reset corner cases
module tb_plic_target_claim;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  plic_target_claim_if bus();
  plic_target_claim #(.PRIORITY_LEVELS(32), .INTERRUPTS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  typedef struct {
    logic [31:0] req;
    bit          we;
    logic [1:0]  sel;
    logic [4:0]  idx;
    logic [31:0] wd;
    int          eclm;
    int          cid;
    int          enot;
    bit          eeip;
  } vec_t;
  vec_t tbl[$];
  int   clm_q[$];
  int   not_q[$];
  int   errors = 0;
  int   checks = 0;
  int   last_id = 0;
  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  function automatic void r(logic [31:0] req, bit we, logic [1:0] sel, logic [4:0] idx, logic [31:0] wd, int eclm, int cid, int enot, bit eeip);
    vec_t v;
    v = '{req, we, sel, idx, wd, eclm, cid, enot, eeip};
    tbl.push_back(v);
  endfunction
  function automatic void p(logic [4:0] idx, logic [31:0] val, bit eeip); r(0, 1, 2'd0, idx, val, -1, -1, -1, eeip); endfunction
  function automatic void en(logic [31:0] val, bit eeip); r(0, 1, 2'd1, 0, val, -1, -1, -1, eeip); endfunction
  function automatic void rq(logic [31:0] req, bit eeip); r(req, 0, 2'd0, 0, 0, -1, -1, -1, eeip); endfunction
  function automatic void cl(int id, bit eeip); r(0, 0, 2'd0, 0, 0, id, -1, -1, eeip); endfunction
  function automatic void cp(int id, int enot, bit eeip); r(0, 0, 2'd0, 0, 0, -1, id, enot, eeip); endfunction
  task automatic idle_inputs();
    bus.interrupt_request = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_sel = '0;
    bus.cfg_idx = '0;
    bus.cfg_wdata = '0;
    bus.claim_req = 1'b0;
    bus.complete_req = 1'b0;
    bus.complete_id = '0;
  endtask
  task automatic check_outputs(string tag);
    if (bus.claim_valid) begin
      if (clm_q.size() == 0) chk({tag, " unexpected claim_valid"}, bus.claim_valid, 0);
      else chk({tag, " claim_id"}, bus.claim_id, clm_q.pop_front());
    end else if (clm_q.size() != 0) begin
      void'(clm_q.pop_front());
      chk({tag, " missing claim_valid"}, bus.claim_valid, 1);
    end
    if (bus.interrupt_completion_notif) begin
      if (not_q.size() == 0) chk({tag, " unexpected notif"}, bus.interrupt_completion_notif, 0);
      else last_id = not_q.pop_front();
    end else if (not_q.size() != 0) begin
      void'(not_q.pop_front());
      chk({tag, " missing notif"}, bus.interrupt_completion_notif, 1);
    end
    chk({tag, " notif_id"}, bus.interrupt_completion_ID, last_id);
  endtask
  task automatic apply(vec_t v, int n);
    bus.interrupt_request = v.req;
    bus.cfg_we = v.we;
    bus.cfg_sel = v.sel;
    bus.cfg_idx = v.idx;
    bus.cfg_wdata = v.wd;
    bus.claim_req = v.eclm >= 0;
    bus.complete_req = v.cid >= 0;
    bus.complete_id = v.cid >= 0 ? 32'(v.cid) : 32'd0;
    if (v.eclm >= 0) clm_q.push_back(v.eclm);
    if (v.enot >= 0) not_q.push_back(v.enot);
    @(posedge clk);
    #1;
    idle_inputs();
    chk($sformatf("row%0d eip", n), bus.eip, v.eeip);
    check_outputs($sformatf("row%0d", n));
  endtask
  initial begin
    idle_inputs();
    p(2, 3, 0);
    en(32'hFF, 0);
    rq(32'h4, 1);
    cl(3, 0);
    cp(3, 3, 0);
    cp(3, -1, 0);
    cp(0, -1, 0);
    cp(9, -1, 0);
    p(1, 5, 0);
    p(4, 5, 0);
    rq(32'h12, 1);
    cl(2, 1);
    cl(5, 0);
    cl(0, 0);
    cp(2, 2, 0);
    cp(5, 5, 0);
    rq(32'h2, 1);
    r(32'h2, 0, 2'd0, 0, 0, 2, -1, -1, 1);
    cl(2, 0);
    cp(2, 2, 0);
    cp(2, -1, 0);
    rq(32'h10, 1);
    cl(5, 0);
    rq(32'h10, 1);
    r(0, 0, 2'd0, 0, 0, 5, 5, 5, 0);
    cp(5, 5, 0);
    cp(5, -1, 0);
    rq(32'h8000_0200, 0);
    p(2, 0, 0);
    rq(32'h4, 0);
    p(2, 7, 0);
    rq(0, 1);
    cl(3, 0);
    cp(3, 3, 0);
    en(0, 0);
    rq(32'h2, 0);
    en(32'hFFFF_FFFF, 0);
    rq(0, 1);
    cl(2, 0);
    cp(2, 2, 0);
    p(5, 40, 0);
    p(1, 30, 0);
    rq(32'h22, 1);
    cl(6, 1);
    cl(2, 0);
    cp(6, 6, 0);
    cp(2, 2, 0);
    r(0, 1, 2'd3, 1, 0, -1, -1, -1, 0);
    r(0, 1, 2'd0, 8, 0, -1, -1, -1, 0);
    rq(32'h2, 1);
    cl(2, 0);
    cp(2, 2, 0);
`ifdef PLIC_THRESHOLD_EN
    r(0, 1, 2'd2, 0, 4, -1, -1, -1, 0);
    p(3, 4, 0);
    rq(32'h8, 0);
    p(3, 5, 0);
    rq(0, 1);
    cl(4, 0);
    cp(4, 4, 0);
    r(0, 1, 2'd2, 0, 0, -1, -1, -1, 0);
`else
    r(0, 1, 2'd2, 0, 4, -1, -1, -1, 0);
    p(3, 4, 0);
    rq(32'h8, 1);
    cl(4, 0);
    cp(4, 4, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset eip", bus.eip, 0);
    chk("reset claim_valid", bus.claim_valid, 0);
    chk("reset claim_id", bus.claim_id, 0);
    chk("reset notif", bus.interrupt_completion_notif, 0);
    chk("reset notif_id", bus.interrupt_completion_ID, 0);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    chk("prio5 saturated", dut.prio[5], 31);
    chk("enable masked", dut.enable, 32'hFF);
    rq(32'h2, 1);
    apply(tbl[tbl.size() - 1], tbl.size() - 1);
    bus.claim_req = 1'b1;
    @(posedge clk);
    #1;
    bus.claim_req = 1'b0;
    chk("pre-reset claim_valid", bus.claim_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset claim_valid", bus.claim_valid, 0);
    chk("mid reset claim_id", bus.claim_id, 0);
    chk("mid reset eip", bus.eip, 0);
    chk("mid reset notif_id", bus.interrupt_completion_ID, 0);
    chk("mid reset pending", dut.pending, 0);
    chk("mid reset in_service", dut.in_service, 0);
    chk("mid reset prio1", dut.prio[1], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post reset claim_valid", bus.claim_valid, 0);
      chk("post reset notif", bus.interrupt_completion_notif, 0);
      chk("post reset eip", bus.eip, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
